// File: rtl/red_pitaya_pid_mimo_seq_if.sv
// System bus bundle for red_pitaya_pid_mimo_seq (address/data/strobes and response).
interface red_pitaya_pid_mimo_seq_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic [3:0]  sys_sel;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  modport master (
    output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    input  sys_rdata, sys_err, sys_ack
  );

  modport slave (
    input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    output sys_rdata, sys_err, sys_ack
  );
endinterface

// File: rtl/red_pitaya_pid_mimo_seq.sv
// CH x CH MIMO PID controller with one time-multiplexed PID datapath.
// Each output j is the saturated sum over inputs i of PID(pair k = j*CH + i).
// Optional feature macro: PID_DERIV_EN (adds the D term and per-pair err_prev storage).
module red_pitaya_pid_mimo_seq #(
  parameter int unsigned CH  = 2,
  parameter int unsigned DW  = 14,
  parameter int unsigned KW  = 14,
  parameter int unsigned PSR = 12,
  parameter int unsigned ISR = 18,
  parameter int unsigned DSR = 10,
  parameter int unsigned IW  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    smp_i,
  input  logic [CH*DW-1:0]        dat_i,
  output logic [CH*DW-1:0]        dat_o,
  output logic                    dat_vld_o,
  output logic                    busy_o,
  red_pitaya_pid_mimo_seq_if.slave bus
);
  localparam int unsigned P   = CH * CH;
  localparam int unsigned KIW = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned CIW = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned SW  = DW + $clog2(CH) + 1;

  typedef logic signed [63:0] wide_t;
  localparam wide_t DMax = (wide_t'(1) <<< (DW - 1)) - wide_t'(1);
  localparam wide_t DMin = -(wide_t'(1) <<< (DW - 1));
  localparam wide_t IMax = (wide_t'(1) <<< (IW - 1)) - wide_t'(1);
  localparam wide_t IMin = -(wide_t'(1) <<< (IW - 1));

  typedef enum logic [2:0] {StIdle, StErr, StMul, StAcc, StSat} state_e;

  function automatic logic signed [DW-1:0] sat_dw(input wide_t v);
    if (v > DMax) return DMax[DW-1:0];
    else if (v < DMin) return DMin[DW-1:0];
    else return v[DW-1:0];
  endfunction

  function automatic logic signed [IW-1:0] sat_iw(input wide_t v);
    if (v > IMax) return IMax[IW-1:0];
    else if (v < IMin) return IMin[IW-1:0];
    else return v[IW-1:0];
  endfunction

  // Configuration registers
  logic signed [DW-1:0] sp_q [P];
  logic signed [KW-1:0] kp_q [P];
  logic signed [KW-1:0] ki_q [P];
`ifdef PID_DERIV_EN
  logic signed [KW-1:0] kd_q [P];
`endif
  logic [P-1:0]         irst_q;
  logic                 ovr_q;
  logic [31:0]          rdata_q, rd_d;
  logic                 ack_q;

  // Sequencer and datapath state
  state_e                state_q, state_d;
  logic [KIW-1:0]        k_q;
  logic [CIW-1:0]        in_q, out_q;
  logic signed [DW-1:0]  x_q [CH];
  logic signed [DW:0]    e_q, e_d;
  logic signed [KW-1:0]  cur_kp_q, cur_ki_q;
  logic signed [DW-1:0]  p_q, p_d;
  logic signed [DW+KW:0] pi_q, prod_p, prod_i;
  logic signed [IW-1:0]  acc_q [P];
  logic signed [IW-1:0]  acc_new;
  logic signed [DW-1:0]  i_term, d_term, pid;
  logic signed [SW-1:0]  sum_q [CH];
  logic signed [DW-1:0]  res_q [CH];
  logic                  pend_q, vld_q;
  logic [CH*DW-1:0]      dat_q;
  logic signed [DW-1:0]  x_sel;
`ifdef PID_DERIV_EN
  logic signed [KW-1:0]    cur_kd_q;
  logic signed [DW:0]      eprev_q [P];
  logic signed [DW+1:0]    e_diff;
  logic signed [DW+KW+1:0] prod_d;
  logic signed [DW-1:0]    d_q, d_d;
`endif

  // Bus decode
  logic [15:0]    blk;
  logic [1:0]     off;
  logic           hit;
  logic [KIW-1:0] ksel;
  logic           unused_bus;

  assign busy_o        = (state_q != StIdle) || pend_q;
  assign dat_o         = dat_q;
  assign dat_vld_o     = vld_q;
  assign bus.sys_rdata = rdata_q;
  assign bus.sys_ack   = ack_q;
  assign bus.sys_err   = 1'b0;
  assign unused_bus    = ^{bus.sys_sel, bus.sys_addr[31:20], bus.sys_addr[1:0], bus.sys_wdata};

  // Address decode and read mux
  always_comb begin
    blk  = bus.sys_addr[19:4];
    off  = bus.sys_addr[3:2];
    hit  = (blk != 16'd0) && (32'(blk) <= P);
    ksel = KIW'(blk - 16'd1);
    rd_d = '0;
    if (bus.sys_addr[19:2] == 18'd0) begin
      rd_d = 32'(irst_q);
    end else if (bus.sys_addr[19:2] == 18'd1) begin
      rd_d = {30'd0, busy_o, ovr_q};
    end else if (hit) begin
      unique case (off)
        2'd0:    rd_d = 32'(sp_q[ksel]);
        2'd1:    rd_d = 32'(kp_q[ksel]);
        2'd2:    rd_d = 32'(ki_q[ksel]);
`ifdef PID_DERIV_EN
        default: rd_d = 32'(kd_q[ksel]);
`else
        default: rd_d = '0;
`endif
      endcase
    end
  end

  // Register writes, read capture, ack and sticky overrun
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned n = 0; n < P; n++) begin
        sp_q[n] <= '0;
        kp_q[n] <= '0;
        ki_q[n] <= '0;
`ifdef PID_DERIV_EN
        kd_q[n] <= '0;
`endif
      end
      irst_q  <= '1;
      ovr_q   <= 1'b0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= bus.sys_wen | bus.sys_ren;
      if (bus.sys_ren) rdata_q <= rd_d;
      if (bus.sys_wen) begin
        if (bus.sys_addr[19:2] == 18'd0) begin
          irst_q <= bus.sys_wdata[P-1:0];
        end else if (bus.sys_addr[19:2] == 18'd1) begin
          if (bus.sys_wdata[0]) ovr_q <= 1'b0;
        end else if (hit) begin
          unique case (off)
            2'd0:    sp_q[ksel] <= bus.sys_wdata[DW-1:0];
            2'd1:    kp_q[ksel] <= bus.sys_wdata[KW-1:0];
            2'd2:    ki_q[ksel] <= bus.sys_wdata[KW-1:0];
`ifdef PID_DERIV_EN
            default: kd_q[ksel] <= bus.sys_wdata[KW-1:0];
`else
            default: ;
`endif
          endcase
        end
      end
      // A new overrun wins over a same-cycle clear
      if (smp_i && busy_o) ovr_q <= 1'b1;
    end
  end

  // Next-state logic of the pair sequencer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (smp_i && !pend_q) state_d = StErr;
      StErr:   state_d = StMul;
      StMul:   state_d = StAcc;
      StAcc:   state_d = (k_q == KIW'(P - 1)) ? StSat : StErr;
      StSat:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Shared PID arithmetic for the pair currently addressed by k_q
  always_comb begin
    x_sel  = x_q[in_q];
    e_d    = (DW+1)'(sp_q[k_q]) - (DW+1)'(x_sel);
    prod_p = (DW+KW+1)'(e_q) * (DW+KW+1)'(cur_kp_q);
    prod_i = (DW+KW+1)'(e_q) * (DW+KW+1)'(cur_ki_q);
    p_d    = sat_dw(wide_t'(prod_p) >>> PSR);
`ifdef PID_DERIV_EN
    e_diff = (DW+2)'(e_q) - (DW+2)'(eprev_q[k_q]);
    prod_d = (DW+KW+2)'(e_diff) * (DW+KW+2)'(cur_kd_q);
    d_d    = sat_dw(wide_t'(prod_d) >>> DSR);
    d_term = d_q;
`else
    d_term = '0;
`endif
    acc_new = sat_iw(wide_t'(acc_q[k_q]) + wide_t'(pi_q));
    i_term  = irst_q[k_q] ? '0 : sat_dw(wide_t'(acc_new) >>> ISR);
    pid     = sat_dw(wide_t'(p_q) + wide_t'(i_term) + wide_t'(d_term));
  end

  // State register, per-pair pipeline and output stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      k_q      <= '0;
      in_q     <= '0;
      out_q    <= '0;
      e_q      <= '0;
      cur_kp_q <= '0;
      cur_ki_q <= '0;
      p_q      <= '0;
      pi_q     <= '0;
      pend_q   <= 1'b0;
      vld_q    <= 1'b0;
      dat_q    <= '0;
      for (int unsigned c = 0; c < CH; c++) begin
        x_q[c]   <= '0;
        sum_q[c] <= '0;
        res_q[c] <= '0;
      end
      for (int unsigned n = 0; n < P; n++) acc_q[n] <= '0;
`ifdef PID_DERIV_EN
      cur_kd_q <= '0;
      d_q      <= '0;
      for (int unsigned n = 0; n < P; n++) eprev_q[n] <= '0;
`endif
    end else begin
      state_q <= state_d;
      vld_q   <= 1'b0;
      // Output register stage, one cycle after SAT
      if (pend_q) begin
        pend_q <= 1'b0;
        vld_q  <= 1'b1;
        for (int unsigned c = 0; c < CH; c++) dat_q[c*DW +: DW] <= res_q[c];
      end
      unique case (state_q)
        StIdle: begin
          if (smp_i && !pend_q) begin
            for (int unsigned c = 0; c < CH; c++) x_q[c] <= dat_i[c*DW +: DW];
          end
        end
        StErr: begin
          e_q      <= e_d;
          cur_kp_q <= kp_q[k_q];
          cur_ki_q <= ki_q[k_q];
`ifdef PID_DERIV_EN
          cur_kd_q <= kd_q[k_q];
`endif
        end
        StMul: begin
          p_q  <= p_d;
          pi_q <= prod_i;
`ifdef PID_DERIV_EN
          d_q          <= d_d;
          eprev_q[k_q] <= e_q;
`endif
        end
        StAcc: begin
          acc_q[k_q]   <= irst_q[k_q] ? '0 : acc_new;
          sum_q[out_q] <= sum_q[out_q] + SW'(pid);
          if (k_q == KIW'(P - 1)) begin
            k_q   <= '0;
            in_q  <= '0;
            out_q <= '0;
          end else begin
            k_q <= k_q + KIW'(1);
            if (in_q == CIW'(CH - 1)) begin
              in_q  <= '0;
              out_q <= out_q + CIW'(1);
            end else begin
              in_q <= in_q + CIW'(1);
            end
          end
        end
        StSat: begin
          for (int unsigned c = 0; c < CH; c++) begin
            res_q[c] <= sat_dw(wide_t'(sum_q[c]));
            sum_q[c] <= '0;
          end
          pend_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
